// File: rtl/axi_spi_pkg.sv
// Shared types and constants for the AXI4-Lite to SPI bridge.
//   state_t      : frame/response sequencing states
//   RESP_*       : AXI response codes
//   SPI_*_BITS   : frame field widths (command byte, data word)
//   cmd_byte()   : packs {reg_idx, rw} into the SPI command byte
package axi_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_GAP,
    ST_DATA,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int SPI_CMD_BITS  = 8;
  localparam int SPI_DATA_BITS = 32;

  function automatic logic [7:0] cmd_byte(input logic [6:0] idx, input logic rw);
    return {idx, rw};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI frame engine: SCLK divider, chip select and the 40-bit shift/sample path.
// One start pulse launches SETUP -> CMD -> GAP -> DATA -> HOLD; done pulses for
// one cycle when the CS-high hold time has elapsed.
//   clk_sys, rst_b : clock, async active-low reset
//   start          : launch a frame; cmd/wdata are captured on this cycle
//   cmd, wdata     : command byte and data word (wdata is zero for reads)
//   miso           : serial data from the peer
//   sclk, mosi, cs : SPI pins (SCLK idle low, CS active low)
//   done           : frame finished, rdata valid
//   rdata          : word shifted in from MISO during the data phase
module spi_shift_engine
  import axi_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CMD_GAP = 16,
  parameter int CS_GAP  = 16
) (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] wdata,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs,
  output logic        done,
  output logic [31:0] rdata
);

  localparam int FRAME_BITS = SPI_CMD_BITS + SPI_DATA_BITS;
  localparam int TMR_W      = $clog2(CLK_DIV + CMD_GAP + CS_GAP + 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLK_DIV - 1);
  localparam logic [5:0] CMD_END  = 6'(SPI_CMD_BITS);
  localparam logic [5:0] DATA_END = 6'(SPI_DATA_BITS);

  state_t                 phase;
  logic [TMR_W-1:0]       tmr;
  logic [5:0]             bit_cnt;
  logic [FRAME_BITS-1:0]  sr;
  logic [31:0]            rx;

  // MOSI is the top of the shift register; zeros shift in, so it idles low.
  assign mosi  = sr[FRAME_BITS-1];
  assign rdata = rx;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      phase   <= ST_IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      rx      <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        ST_IDLE: begin
          if (start) begin
            phase <= ST_SETUP;
            cs    <= 1'b0;
            sr    <= {cmd, wdata};
            tmr   <= HALF_LOAD;
          end
        end
        ST_SETUP: begin
          if (tmr == '0) begin
            phase   <= ST_CMD;
            sclk    <= 1'b1;
            bit_cnt <= '0;
            tmr     <= HALF_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_CMD, ST_DATA: begin
          // Each SCLK period is a high half followed by a low half. The
          // falling edge advances MOSI and samples MISO; the phase ends
          // after the low half of its last period.
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (sclk) begin
            sclk    <= 1'b0;
            sr      <= {sr[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            tmr     <= HALF_LOAD;
            if (phase == ST_DATA) rx <= {rx[30:0], miso};
          end else if (phase == ST_CMD && bit_cnt == CMD_END) begin
            phase <= ST_GAP;
            tmr   <= TMR_W'(CMD_GAP - 1);
          end else if (phase == ST_DATA && bit_cnt == DATA_END) begin
            phase <= ST_HOLD;
            cs    <= 1'b1;
            tmr   <= TMR_W'(CS_GAP - 1);
          end else begin
            sclk <= 1'b1;
            tmr  <= HALF_LOAD;
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            phase   <= ST_DATA;
            sclk    <= 1'b1;
            bit_cnt <= '0;
            tmr     <= HALF_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr == '0) begin
            phase <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_spi_master.sv
// AXI4-Lite slave that converts each single-beat write/read into one SPI frame:
// command byte {reg_idx[6:0], rw} followed by 32 data bits, MSB first.
//   AXI_ACLK, AXI_ARESETN : clock, async active-low reset
//   AXI_AW*/W*/B*         : write channel (reg_idx = AWADDR[8:2]; WSTRB/AWPROT ignored)
//   AXI_AR*/R*            : read channel  (reg_idx = ARADDR[8:2]; ARPROT ignored)
//   SCLK, MOSI, MISO, CS  : SPI master pins
//   busy                  : request accepted and response not yet taken
// Build option: define ADDR_RANGE_CHECK_EN to reject reg_idx 0 or > NUM_REGS
// with SLVERR and no SPI frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; READY pulses are issued here
// ST_SETUP | frame handed to spi_shift_engine (SETUP..HOLD), wait done
// ST_RESP  | BVALID or RVALID held until the master takes it
module axi_lite_spi_master
  import axi_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CMD_GAP  = 16,
  parameter int CS_GAP   = 16,
  parameter int NUM_REGS = 5
) (
  input  logic        AXI_ACLK,
  input  logic        AXI_ARESETN,
  input  logic [31:0] AXI_AWADDR,
  input  logic [2:0]  AXI_AWPROT,
  input  logic        AXI_AWVALID,
  output logic        AXI_AWREADY,
  input  logic [31:0] AXI_WDATA,
  input  logic [3:0]  AXI_WSTRB,
  input  logic        AXI_WVALID,
  output logic        AXI_WREADY,
  output logic [1:0]  AXI_BRESP,
  output logic        AXI_BVALID,
  input  logic        AXI_BREADY,
  input  logic [31:0] AXI_ARADDR,
  input  logic [2:0]  AXI_ARPROT,
  input  logic        AXI_ARVALID,
  output logic        AXI_ARREADY,
  output logic [31:0] AXI_RDATA,
  output logic [1:0]  AXI_RRESP,
  output logic        AXI_RVALID,
  input  logic        AXI_RREADY,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS,
  output logic        busy
);

  state_t      state;
  logic        is_wr;
  logic [6:0]  wr_idx, rd_idx;
  logic        wr_ok, rd_ok;
  logic        acc_wr, acc_rd;
  logic        eng_start, eng_done;
  logic [7:0]  eng_cmd;
  logic [31:0] eng_wdata, eng_rdata;
  logic        unused;

  assign unused = ^{AXI_AWADDR[31:9], AXI_AWADDR[1:0], AXI_ARADDR[31:9],
                    AXI_ARADDR[1:0], AXI_AWPROT, AXI_ARPROT, AXI_WSTRB};

  assign wr_idx = AXI_AWADDR[8:2];
  assign rd_idx = AXI_ARADDR[8:2];

`ifdef ADDR_RANGE_CHECK_EN
  assign wr_ok = (wr_idx != 7'd0) && (int'(wr_idx) <= NUM_REGS);
  assign rd_ok = (rd_idx != 7'd0) && (int'(rd_idx) <= NUM_REGS);
`else
  localparam int unused_num_regs = NUM_REGS;
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // READY pulses are mutually exclusive, so at most one accept per cycle.
  assign acc_wr = AXI_AWREADY & AXI_AWVALID & AXI_WREADY & AXI_WVALID;
  assign acc_rd = AXI_ARREADY & AXI_ARVALID;

  // The engine captures command and data on the accept cycle itself.
  assign eng_start = (acc_wr & wr_ok) | (acc_rd & rd_ok);
  assign eng_cmd   = acc_wr ? cmd_byte(wr_idx, 1'b1) : cmd_byte(rd_idx, 1'b0);
  assign eng_wdata = acc_wr ? AXI_WDATA : 32'd0;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .CMD_GAP (CMD_GAP),
    .CS_GAP  (CS_GAP)
  ) u_engine (
    .clk_sys (AXI_ACLK),
    .rst_b   (AXI_ARESETN),
    .start   (eng_start),
    .cmd     (eng_cmd),
    .wdata   (eng_wdata),
    .miso    (MISO),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .cs      (CS),
    .done    (eng_done),
    .rdata   (eng_rdata)
  );

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state       <= ST_IDLE;
      is_wr       <= 1'b0;
      AXI_AWREADY <= 1'b0;
      AXI_WREADY  <= 1'b0;
      AXI_ARREADY <= 1'b0;
      AXI_BVALID  <= 1'b0;
      AXI_BRESP   <= RESP_OKAY;
      AXI_RVALID  <= 1'b0;
      AXI_RRESP   <= RESP_OKAY;
      AXI_RDATA   <= '0;
      busy        <= 1'b0;
    end else begin
      AXI_AWREADY <= 1'b0;
      AXI_WREADY  <= 1'b0;
      AXI_ARREADY <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_wr) begin
            is_wr <= 1'b1;
            busy  <= 1'b1;
            if (wr_ok) begin
              state <= ST_SETUP;
            end else begin
              state      <= ST_RESP;
              AXI_BVALID <= 1'b1;
              AXI_BRESP  <= RESP_SLVERR;
            end
          end else if (acc_rd) begin
            is_wr <= 1'b0;
            busy  <= 1'b1;
            if (rd_ok) begin
              state <= ST_SETUP;
            end else begin
              state      <= ST_RESP;
              AXI_RVALID <= 1'b1;
              AXI_RRESP  <= RESP_SLVERR;
              AXI_RDATA  <= '0;
            end
          end else if (!(AXI_AWREADY | AXI_ARREADY)) begin
            // Write wins; a read is only offered when no full write is pending.
            if (AXI_AWVALID && AXI_WVALID) begin
              AXI_AWREADY <= 1'b1;
              AXI_WREADY  <= 1'b1;
            end else if (AXI_ARVALID) begin
              AXI_ARREADY <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (eng_done) begin
            state <= ST_RESP;
            if (is_wr) begin
              AXI_BVALID <= 1'b1;
              AXI_BRESP  <= RESP_OKAY;
            end else begin
              AXI_RVALID <= 1'b1;
              AXI_RRESP  <= RESP_OKAY;
              AXI_RDATA  <= eng_rdata;
            end
          end
        end
        ST_RESP: begin
          if ((AXI_BVALID && AXI_BREADY) || (AXI_RVALID && AXI_RREADY)) begin
            AXI_BVALID <= 1'b0;
            AXI_RVALID <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_spi_master.sv
module tb_axi_lite_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CMD_GAP  = 16;
  localparam int CS_GAP   = 16;
  localparam int NUM_REGS = 5;
  localparam int LATENCY  = CLK_DIV + 16*CLK_DIV + CMD_GAP + 64*CLK_DIV + CS_GAP + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA;
  logic [3:0]  WSTRB = 4'hF;
  logic        AWVALID = 0, WVALID = 0, ARVALID = 0, BREADY = 0, RREADY = 0;
  logic        AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic        SCLK, MOSI, CS, busy;
  logic        MISO = 1'b0;

  always #5 clk = ~clk;

  axi_lite_spi_master #(.CLK_DIV(CLK_DIV), .CMD_GAP(CMD_GAP), .CS_GAP(CS_GAP), .NUM_REGS(NUM_REGS)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .AXI_AWADDR(AWADDR), .AXI_AWPROT(3'b000), .AXI_AWVALID(AWVALID), .AXI_AWREADY(AWREADY),
    .AXI_WDATA(WDATA), .AXI_WSTRB(WSTRB), .AXI_WVALID(WVALID), .AXI_WREADY(WREADY),
    .AXI_BRESP(BRESP), .AXI_BVALID(BVALID), .AXI_BREADY(BREADY),
    .AXI_ARADDR(ARADDR), .AXI_ARPROT(3'b000), .AXI_ARVALID(ARVALID), .AXI_ARREADY(ARREADY),
    .AXI_RDATA(RDATA), .AXI_RRESP(RRESP), .AXI_RVALID(RVALID), .AXI_RREADY(RREADY),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // SPI peer model: register file addressed by the command byte
  logic [31:0] peer_regs [128];
  logic [31:0] exp_regs  [128];
  bit          bits_q [$];
  logic [7:0]  f_cmd_q [$];
  logic [31:0] f_data_q [$];
  int          f_bits_q [$];
  bit          in_frame = 0;
  int          n_frames = 0;
  time         t_rise = 0;
  int          last_gap = -1;
  int          overlap = 0;
  int          busy_err = 0;
  int          early = 0;

  function automatic logic [31:0] field(input int from, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (from + i < bits_q.size()) ? bits_q[from + i] : 1'b0};
    return v;
  endfunction

  always @(negedge CS) begin
    if (n_frames > 0) last_gap = int'((($time - t_rise) / 10));
    bits_q.delete();
    in_frame = 1;
  end

  always @(posedge SCLK) begin
    int k;
    logic [7:0] c;
    if (in_frame && CS === 1'b0) begin
      k = bits_q.size();
      bits_q.push_back(MOSI);
      if (k >= 8 && k < 40) begin
        c = field(0, 8)[7:0];
        if (c[0] == 1'b0) MISO = peer_regs[c[7:1]][31 - (k - 8)];
      end
    end
  end

  always @(posedge CS) begin
    logic [7:0]  c;
    logic [31:0] d;
    if (in_frame) begin
      in_frame = 0;
      t_rise = $time;
      n_frames++;
      c = field(0, 8)[7:0];
      d = field(8, 32);
      f_cmd_q.push_back(c);
      f_data_q.push_back(d);
      f_bits_q.push_back(bits_q.size());
      if (bits_q.size() == 40 && c[0]) peer_regs[c[7:1]] = d;
      MISO = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (BVALID === 1'b1 && RVALID === 1'b1) overlap++;
    if (CS === 1'b0 && busy !== 1'b1) busy_err++;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int wdelay,
                           output logic [1:0] resp, output int lat);
    int  n;
    time t_acc;
    @(posedge clk); #1;
    AWADDR = addr; WDATA = data; AWVALID = 1;
    if (wdelay == 0) WVALID = 1;
    else begin
      for (int i = 0; i < wdelay; i++) begin
        @(negedge clk);
        if (AWREADY || WREADY || !CS) early++;
      end
      @(posedge clk); #1;
      WVALID = 1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(AWREADY && WREADY) && n < 50);
    check("wr_accept", {AWREADY, WREADY}, 2'b11);
    @(posedge clk); t_acc = $time; #1;
    AWVALID = 0; WVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!BVALID && n < 2000);
    check("wr_bvalid", BVALID, 1);
    lat = int'((($time - 5 - t_acc) / 10));
    resp = BRESP;
    BREADY = 1; @(posedge clk); #1; BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    ARADDR = addr; ARVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
    check("rd_accept", ARREADY, 1);
    @(posedge clk); #1;
    ARVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < 2000);
    check("rd_rvalid", RVALID, 1);
    resp = RRESP; data = RDATA;
    RREADY = 1; @(posedge clk); #1; RREADY = 0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, d;
    int          lat, nf, n, idx, wd;
    bit          rw, ok;

    for (int i = 0; i < 128; i++) begin
      peer_regs[i] = $urandom;
      exp_regs[i]  = peer_regs[i];
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_handshake", {AWREADY, WREADY, ARREADY, BVALID, RVALID, busy}, 6'b0);
    check("rst_resp", {BRESP, RRESP}, 4'b0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_spi", {CS, SCLK, MOSI}, 3'b100);
    rst_n = 1;
    repeat (2) @(posedge clk);

    // 1: write idx 2
    nf = n_frames;
    axi_write(32'h8, 32'hA5A5_0F0F, 0, resp, lat);
    check("t1_frames", n_frames - nf, 1);
    check("t1_cmd", f_cmd_q[nf], 8'h05);
    check("t1_data", f_data_q[nf], 32'hA5A5_0F0F);
    check("t1_bits", f_bits_q[nf], 40);
    check("t1_bresp", resp, 2'b00);
    check("t1_latency", lat, LATENCY);
    exp_regs[2] = 32'hA5A5_0F0F;
    @(negedge clk);
    check("t1_busy_idle", busy, 0);

    // 2: read idx 3 returning 0x90
    peer_regs[3] = 32'h90; exp_regs[3] = 32'h90;
    nf = n_frames;
    axi_read(32'hC, resp, rd);
    check("t2_cmd", f_cmd_q[nf], 8'h06);
    check("t2_bits", f_bits_q[nf], 40);
    check("t2_rdata", rd, 32'h0000_0090);
    check("t2_rresp", resp, 2'b00);

    // 3: write and read requested together
    nf = n_frames;
    d = $urandom;
    @(posedge clk); #1;
    AWADDR = 32'h4; WDATA = d; AWVALID = 1; WVALID = 1; ARADDR = 32'h10; ARVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
    check("t3_awready", {AWREADY, WREADY}, 2'b11);
    check("t3_arready_low", ARREADY, 0);
    @(posedge clk); #1; AWVALID = 0; WVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!BVALID && n < 2000);
    check("t3_bvalid", BVALID, 1);
    check("t3_bresp", BRESP, 2'b00);
    BREADY = 1; @(posedge clk); #1; BREADY = 0;
    exp_regs[1] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
    check("t3_arready", ARREADY, 1);
    @(posedge clk); #1; ARVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < 2000);
    check("t3_rvalid", RVALID, 1);
    check("t3_rdata", RDATA, exp_regs[4]);
    RREADY = 1; @(posedge clk); #1; RREADY = 0;
    check("t3_frames", n_frames - nf, 2);
    check("t3_first_cmd", f_cmd_q[nf], 8'h03);
    check("t3_second_cmd", f_cmd_q[nf + 1], 8'h08);
    check("t3_write_data", f_data_q[nf], d);
    check("t3_cs_gap_ok", last_gap >= CS_GAP, 1);

    // 4: WVALID delayed 10 cycles
    nf = n_frames; early = 0;
    d = $urandom;
    axi_write(32'h14, d, 10, resp, lat);
    exp_regs[5] = d;
    check("t4_no_early_ready", early, 0);
    check("t4_frames", n_frames - nf, 1);
    check("t4_cmd", f_cmd_q[nf], 8'h0B);
    check("t4_data", f_data_q[nf], d);

    // 5: reset in the middle of the data phase
    nf = n_frames;
    @(posedge clk); #1;
    AWADDR = 32'h8; WDATA = $urandom; AWVALID = 1; WVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
    @(posedge clk); #1; AWVALID = 0; WVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (bits_q.size() < 29 && n < 3000);
    check("t5_reached_bit20", bits_q.size(), 29);
    rst_n = 0;
    #1;
    check("t5_rst_spi", {CS, SCLK}, 2'b10);
    check("t5_rst_bvalid", BVALID, 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    check("t5_aborted_bits", f_bits_q[nf], 29);
    repeat (2) @(posedge clk);
    nf = n_frames;
    d = $urandom;
    axi_write(32'h8, d, 0, resp, lat);
    exp_regs[2] = d;
    check("t5_post_bresp", resp, 2'b00);
    check("t5_post_data", f_data_q[nf], d);
    axi_read(32'h8, resp, rd);
    check("t5_readback", rd, exp_regs[2]);

    // 6: out-of-range read, idx 16
    nf = n_frames;
    axi_read(32'h40, resp, rd);
`ifdef ADDR_RANGE_CHECK_EN
    check("t6_no_frame", n_frames - nf, 0);
    check("t6_rresp", resp, 2'b10);
    check("t6_rdata", rd, 32'h0);
`else
    check("t6_frames", n_frames - nf, 1);
    check("t6_cmd", f_cmd_q[nf], 8'h20);
    check("t6_rresp", resp, 2'b00);
    check("t6_rdata", rd, exp_regs[16]);
`endif

    // randomized transactions against the register-file model
    for (int it = 0; it < 10; it++) begin
      idx = $urandom_range(0, 8);
      rw  = 1'($urandom_range(0, 1));
      d   = $urandom;
      wd  = $urandom_range(0, 3);
`ifdef ADDR_RANGE_CHECK_EN
      ok = (idx != 0) && (idx <= NUM_REGS);
`else
      ok = 1;
`endif
      nf = n_frames;
      if (rw) begin
        axi_write(32'(idx * 4), d, wd, resp, lat);
        check("rnd_bresp", resp, ok ? 2'b00 : 2'b10);
        if (ok) begin
          exp_regs[idx] = d;
          check("rnd_wdata", f_data_q[nf], d);
        end
      end else begin
        axi_read(32'(idx * 4), resp, rd);
        check("rnd_rresp", resp, ok ? 2'b00 : 2'b10);
        check("rnd_rdata", rd, ok ? exp_regs[idx] : 32'h0);
      end
      check("rnd_frames", n_frames - nf, ok ? 1 : 0);
      if (ok) check("rnd_cmd", f_cmd_q[nf], 32'(idx * 2 + int'(rw)));
    end

    check("valid_overlap", overlap, 0);
    check("busy_during_frame", busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
